fft_twiddle_gen: RTL

Parametrised twiddle-factor generator for the radix-2 DIF FFT datapath. It replaces fixed per-size twiddle ROMs with a single loadable quarter-wave cosine table and a stage sequencer. On request it streams W_N^k = cos(2πk/N) − j·sin(2πk/N) for every butterfly group of one FFT stage, with valid/ready backpressure toward the butterfly unit.

---
 rtl/fft_twiddle_gen.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/fft_twiddle_gen.sv
// Twiddle-factor generator for a radix-2 DIF FFT: loadable quarter-wave cosine table plus a
// stage sequencer that streams W_N^k for every butterfly group of one stage.
module fft_twiddle_gen #(
  parameter int unsigned DW    = 16,
  parameter int unsigned LOG2N = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tbl_we,
  input  logic [LOG2N-2:0]           tbl_waddr,
  input  logic [DW-1:0]              tbl_wdata,
  input  logic                       start,
  input  logic [$clog2(LOG2N)-1:0]   stage,
  output logic                       busy,
  output logic                       done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              tw_re,
  output logic [DW-1:0]              tw_im,
  output logic [LOG2N-2:0]           tw_k
);

  localparam int unsigned N    = 1 << LOG2N;
  localparam int unsigned KW   = LOG2N - 1;
  localparam int unsigned SW   = $clog2(LOG2N);
  localparam int unsigned QTR  = N / 4;
  localparam int unsigned HALF = N / 2;
  localparam int unsigned TD   = QTR + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d, s_start, issue_s;
  logic [KW-1:0]   j_q, j_d, issue_j, issue_k;
  logic            issue, issue_last, stall, accept_last, done_d, done_q;
  logic            quad_lo;
  logic [KW-1:0]   idx_a, idx_b;

  logic [DW-1:0]   tbl_q [TD];

  // P1: exponent and table indices
  logic            v1_q, last1_q, negre1_q;
  logic [KW-1:0]   k1_q, ia1_q, ib1_q;
  // P2: table read data
  logic            v2_q, last2_q, negre2_q;
  logic [KW-1:0]   k2_q;
  logic [DW-1:0]   ra2_q, rb2_q;
  // P3: output registers
  logic            out_valid_q, last3_q;
  logic [DW-1:0]   tw_re_q, tw_im_q;
  logic [KW-1:0]   tw_k_q;

  // Index of the last group in stage s: M-1 = (N/2 >> s) - 1.
  function automatic logic [KW-1:0] last_index(input logic [SW-1:0] s);
    last_index = KW'((HALF >> s) - 1);
  endfunction

  // Two's-complement negate; the most negative code maps to the most positive one.
  function automatic logic [DW-1:0] sat_neg(input logic [DW-1:0] x);
    if (x == {1'b1, {(DW-1){1'b0}}}) begin
      sat_neg = {1'b0, {(DW-1){1'b1}}};
    end else begin
      sat_neg = '0 - x;
    end
  endfunction

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign tw_re     = tw_re_q;
  assign tw_im     = tw_im_q;
  assign tw_k      = tw_k_q;

  assign stall       = out_valid_q && !out_ready;
  assign accept_last = out_valid_q && out_ready && last3_q;
  assign s_start     = (stage > SW'(LOG2N - 1)) ? SW'(LOG2N - 1) : stage;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    issue   = 1'b0;
    issue_j = '0;
    issue_s = s_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        // The accepting edge already issues j = 0, which keeps first-word latency at three.
        if (start) begin
          issue   = 1'b1;
          issue_s = s_start;
          s_d     = s_start;
          j_d     = KW'(1);
          state_d = (last_index(s_start) == '0) ? StDrain : StRun;
        end
      end
      StRun: begin
        if (!stall) begin
          issue   = 1'b1;
          issue_j = j_q;
          j_d     = j_q + KW'(1);
          if (j_q == last_index(s_q)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (accept_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    issue_k    = issue_j << issue_s;
    issue_last = (issue_j == last_index(issue_s));
    quad_lo    = (issue_k < KW'(QTR));
    idx_a      = quad_lo ? issue_k : KW'(HALF - 32'(issue_k));
    idx_b      = quad_lo ? (KW'(QTR) - issue_k) : (issue_k - KW'(QTR));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      s_q     <= '0;
      j_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      j_q     <= j_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TD; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (tbl_we && !busy && (tbl_waddr <= KW'(QTR))) begin
      tbl_q[tbl_waddr] <= tbl_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      negre1_q    <= 1'b0;
      k1_q        <= '0;
      ia1_q       <= '0;
      ib1_q       <= '0;
      v2_q        <= 1'b0;
      last2_q     <= 1'b0;
      negre2_q    <= 1'b0;
      k2_q        <= '0;
      ra2_q       <= '0;
      rb2_q       <= '0;
      out_valid_q <= 1'b0;
      last3_q     <= 1'b0;
      tw_re_q     <= '0;
      tw_im_q     <= '0;
      tw_k_q      <= '0;
    end else if (!stall) begin
      v1_q <= issue;
      if (issue) begin
        last1_q  <= issue_last;
        negre1_q <= !quad_lo;
        k1_q     <= issue_k;
        ia1_q    <= idx_a;
        ib1_q    <= idx_b;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        last2_q  <= last1_q;
        negre2_q <= negre1_q;
        k2_q     <= k1_q;
        ra2_q    <= tbl_q[ia1_q];
        rb2_q    <= tbl_q[ib1_q];
      end
      out_valid_q <= v2_q;
      if (v2_q) begin
        last3_q <= last2_q;
        tw_k_q  <= k2_q;
        tw_re_q <= negre2_q ? sat_neg(ra2_q) : ra2_q;
        tw_im_q <= sat_neg(rb2_q);
      end
    end
  end

endmodule
